evbox_out_seq: RTL and testbench
================================

Name: evbox_out_seq

Overview:
- Sequencer and arbiter for the N-bit LC/GC event output port of the infiTOF event IO box.
- Two requesters share the port: host commands (valid/ready) and an external injection trigger with a preset pattern.
- Each request either latches levels permanently or drives a timed pulse on masked bits. Its data_out feeds the event output pins directly.

Parameters:
- N, 4, number of event output bits
- W, 32, pulse-width counter width
- RST_VAL, 0 (N bits), data_out and base level after reset

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  host command accepted when cmd_valid & cmd_ready at the rising edge
- cmd_mask  input  N  bits affected by the command
- cmd_level  input  N  level driven on masked bits
- cmd_width  input  W  pulse length in cycles; 0 = latch level permanently
- inj_trig  input  1  asynchronous injection trigger; rising edge is the event
- inj_mask  input  N  injection bit mask (quasi-static)
- inj_level  input  N  injection level (quasi-static)
- inj_width  input  W  injection pulse width; 0 = latch permanently
- clr_overrun  input  1  clears inj_overrun
- data_out  output  N  registered event output to the pins
- busy  output  1  high while a pulse is active
- inj_pending  output  1  injection waiting for service
- inj_overrun  output  1  sticky: injection edge lost
- inj_count  output  16  serviced injections, wraps 0xFFFF->0

Behaviour:
- Reset (async, reset_n=0):
  - data_out = base = RST_VAL; state = IDLE.
  - Counter 0; busy, inj_pending, inj_overrun = 0; inj_count = 0.
  - Synchronizer flops = 0.
  - A reset mid-pulse aborts the pulse immediately, with no restore sequencing.
- Trigger path:
  - inj_trig passes through 2 flops (s1, s2), then a delay flop p.
  - edge = s2 & ~p.
  - If inj_trig is first sampled high at edge t, edge is true during cycle t+1 and acts at edge t+2.
- Pattern: pat(mask, level) = (base & ~mask) | (level & mask).
- State IDLE:
  - cmd_ready = 1 iff state = IDLE, edge = 0 and inj_pending = 0.
  - Priority: pending injection > new edge > host command.
  - Service of a request with width 0: base <= pat and data_out <= pat; stay IDLE.
  - Service of a request with width > 0: data_out <= pat; cnt <= width-1; base unchanged; go to PULSE.
  - Servicing an injection increments inj_count and clears inj_pending.
- State PULSE:
  - busy = 1; cmd_ready = 0.
  - If cnt = 0: data_out <= base; go to IDLE. Otherwise cnt <= cnt-1.
  - data_out holds the pulse pattern for exactly width cycles.
  - At least one base cycle always follows a pulse before the next request is applied.
- Edge while PULSE, or while inj_pending = 1 in IDLE:
  - If inj_pending = 0, set inj_pending.
  - If inj_pending = 1, set inj_overrun (sticky); the edge is dropped.
- inj_overrun:
  - clr_overrun clears it.
  - If clr_overrun and a new overrun occur in the same cycle, set wins.
- Latency:
  - Host command accepted at edge a: data_out changes at edge a.
  - inj_trig: data_out changes 2 cycles after first sample when IDLE.
- Width = 1 produces a 1-cycle pulse.
- Width = 2^W-1 is legal, with no overflow; the counter never wraps.
- Masked bits not in mask are never disturbed.
- cmd_mask = 0 with width > 0: port is busy for width cycles with data_out unchanged.

Test Plan:
- Reset with RST_VAL=0: hold reset_n=0, pulse clk -> data_out=0, cmd_ready=1, busy=0. Release and send mask=4'b0011, level=4'b0001, width=0 -> data_out=4'b0001 from accept edge and persists.
- With base=4'b0001, send mask=4'b1000, level=4'b1000, width=5 -> data_out=4'b1001 for exactly 5 cycles, then 4'b0001. busy=1 for 5 cycles; cmd_ready=0 for those cycles.
- inj_trig rise while IDLE with inj_mask=4'b0100, inj_level=4'b0100, inj_width=3 -> data_out bit2 high 2 cycles after first sample, for 3 cycles; inj_count=1.
- Simultaneous cmd_valid and injection edge in IDLE -> injection serviced; cmd_ready=0 that cycle. Command is accepted on the first IDLE cycle after the injection pulse ends.
- Three inj_trig edges during a 100-cycle host pulse -> inj_pending=1 after the first, inj_overrun=1 after the second. One injection is serviced after the pulse; inj_count increments by 1. clr_overrun -> inj_overrun=0.
- Assert reset_n low mid-pulse (width=50, cycle 20) -> data_out=RST_VAL immediately, inj_pending=0, busy=0. Next command works normally.

Source files
------------

// File: rtl/evbox_out_seq.sv
// Event output sequencer/arbiter for the infiTOF event IO box: host commands and a
// synchronized injection trigger share an N-bit port, each latching levels or pulsing masked bits.
module evbox_out_seq #(
  parameter int unsigned    N       = 4,
  parameter int unsigned    W       = 32,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_mask,
  input  logic [N-1:0] cmd_level,
  input  logic [W-1:0] cmd_width,
  input  logic         inj_trig,
  input  logic [N-1:0] inj_mask,
  input  logic [N-1:0] inj_level,
  input  logic [W-1:0] inj_width,
  input  logic         clr_overrun,
  output logic [N-1:0] data_out,
  output logic         busy,
  output logic         inj_pending,
  output logic         inj_overrun,
  output logic [15:0]  inj_count
);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t       state;
  logic [N-1:0] base;
  logic [W-1:0] cnt;
  logic         s1, s2, p;
  logic         trig_edge;

  logic         svc_inj, svc_cmd, edge_blocked, set_pending, set_overrun;
  logic [N-1:0] sel_mask, sel_level, pat;
  logic [W-1:0] sel_width;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= inj_trig;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign trig_edge = s2 & ~p;
  assign cmd_ready = (state == IDLE) & ~trig_edge & ~inj_pending;
  assign busy      = (state == PULSE);

  always_comb begin
    svc_inj      = (state == IDLE) & (inj_pending | trig_edge);
    svc_cmd      = cmd_valid & cmd_ready;
    // an edge that cannot be serviced right now is queued once, then counted as lost
    edge_blocked = trig_edge & ((state == PULSE) | inj_pending);
    set_pending  = edge_blocked & ~inj_pending;
    set_overrun  = edge_blocked & inj_pending;
    sel_mask     = svc_inj ? inj_mask  : cmd_mask;
    sel_level    = svc_inj ? inj_level : cmd_level;
    sel_width    = svc_inj ? inj_width : cmd_width;
    pat          = (base & ~sel_mask) | (sel_level & sel_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      data_out    <= RST_VAL;
      base        <= RST_VAL;
      cnt         <= '0;
      inj_pending <= 1'b0;
      inj_overrun <= 1'b0;
      inj_count   <= '0;
    end else begin
      inj_pending <= set_pending | (inj_pending & ~svc_inj);
      inj_overrun <= set_overrun | (inj_overrun & ~clr_overrun);
      if (svc_inj) inj_count <= inj_count + 16'd1;

      case (state)
        IDLE: begin
          if (svc_inj || svc_cmd) begin
            data_out <= pat;
            if (sel_width == '0) begin
              base <= pat;
            end else begin
              cnt   <= sel_width - 1'b1;
              state <= PULSE;
            end
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            data_out <= base;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evbox_out_seq.sv
// Self-checking bench for evbox_out_seq: vector table of host commands plus
// hand-written injection, arbitration, overrun and mid-pulse reset sequences.
module tb_evbox_out_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_mask = '0, cmd_level = '0;
  logic [31:0] cmd_width = '0;
  logic        inj_trig = 1'b0;
  logic [3:0]  inj_mask = '0, inj_level = '0;
  logic [31:0] inj_width = '0;
  logic        clr_overrun = 1'b0;
  logic [3:0]  data_out;
  logic        busy, inj_pending, inj_overrun;
  logic [15:0] inj_count;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  level;
    logic [31:0] width;
    logic [3:0]  pat;
    logic [3:0]  base;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       busy;
    logic       ready;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  evbox_out_seq #(.N(4), .W(32), .RST_VAL(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask), .cmd_level(cmd_level), .cmd_width(cmd_width),
    .inj_trig(inj_trig), .inj_mask(inj_mask), .inj_level(inj_level), .inj_width(inj_width),
    .clr_overrun(clr_overrun),
    .data_out(data_out), .busy(busy), .inj_pending(inj_pending),
    .inj_overrun(inj_overrun), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [3:0] d, input logic b, input logic r);
    exp_t e;
    e.data = d; e.busy = b; e.ready = r;
    q.push_back(e);
  endtask

  // Pops one expected record per cycle, comparing at the falling edge.
  task automatic run_q(input int drop_at);
    exp_t e;
    int   idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("data_out[%0d]", idx), 32'(data_out), 32'(e.data));
      chk($sformatf("busy[%0d]", idx), 32'(busy), 32'(e.busy));
      chk($sformatf("cmd_ready[%0d]", idx), 32'(cmd_ready), 32'(e.ready));
      if (idx == drop_at) cmd_valid = 1'b0;
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic start_cmd(input logic [3:0] m, input logic [3:0] l, input logic [31:0] w);
    chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_mask = m; cmd_level = l; cmd_width = w;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] m, input logic [3:0] l, input logic [31:0] w,
                          input logic [3:0] pat, input logic [3:0] base);
    start_cmd(m, l, w);
    for (int i = 0; i < int'(w); i++) push(pat, 1'b1, 1'b0);
    push(base, 1'b0, 1'b1);
    run_q(-1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0011, 4'b0001, 32'd0, 4'b0001, 4'b0001};
    vecs[1] = '{4'b1000, 4'b1000, 32'd5, 4'b1001, 4'b0001};
    vecs[2] = '{4'b0110, 4'b0110, 32'd1, 4'b0111, 4'b0001};
    vecs[3] = '{4'b0000, 4'b1111, 32'd3, 4'b0001, 4'b0001};
    vecs[4] = '{4'b1111, 4'b1010, 32'd0, 4'b1010, 4'b1010};
    vecs[5] = '{4'b0101, 4'b0101, 32'd2, 4'b1111, 4'b1010};
    vecs[6] = '{4'b0010, 4'b0000, 32'd0, 4'b1000, 4'b1000};
    vecs[7] = '{4'b1111, 4'b0000, 32'd0, 4'b0000, 4'b0000};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inj_count", 32'(inj_count), 32'd0);
    chk("rst_inj_overrun", 32'(inj_overrun), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) send_cmd(vecs[i].mask, vecs[i].level, vecs[i].width, vecs[i].pat, vecs[i].base);

    // injection while idle: output moves 2 cycles after first sample
    inj_mask = 4'b0100; inj_level = 4'b0100; inj_width = 32'd3;
    inj_trig = 1'b1;
    @(negedge clk);
    push(4'b0000, 1'b0, 1'b1);
    push(4'b0000, 1'b0, 1'b0);
    repeat (3) push(4'b0100, 1'b1, 1'b0);
    push(4'b0000, 1'b0, 1'b1);
    run_q(-1);
    inj_trig = 1'b0;
    chk("inj_count_1", 32'(inj_count), 32'd1);
    chk("inj_pending_1", 32'(inj_pending), 32'd0);
    repeat (4) @(negedge clk);

    // command raised while the edge is live loses to the injection
    inj_trig = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_low_on_edge", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_mask = 4'b0001; cmd_level = 4'b0001; cmd_width = 32'd2;
    @(negedge clk);
    repeat (3) push(4'b0100, 1'b1, 1'b0);
    push(4'b0000, 1'b0, 1'b1);
    repeat (2) push(4'b0001, 1'b1, 1'b0);
    push(4'b0000, 1'b0, 1'b1);
    run_q(4);
    inj_trig = 1'b0;
    chk("inj_count_2", 32'(inj_count), 32'd2);
    repeat (4) @(negedge clk);

    // three edges during a long host pulse
    start_cmd(4'b0001, 4'b0001, 32'd100);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      inj_trig = 1'b1;
      repeat (4) @(negedge clk);
      inj_trig = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("ovr_pending_%0d", k), 32'(inj_pending), 32'd1);
      chk($sformatf("ovr_overrun_%0d", k), 32'(inj_overrun), (k == 0) ? 32'd0 : 32'd1);
    end
    chk("ovr_still_busy", 32'(busy), 32'd1);
    chk("ovr_hold_data", 32'(data_out), 32'b0001);
    wait_idle(200);
    chk("ovr_base_gap", 32'(data_out), 32'd0);
    chk("ovr_pending_gap", 32'(inj_pending), 32'd1);
    @(negedge clk);
    chk("ovr_inj_data", 32'(data_out), 32'b0100);
    chk("ovr_inj_count", 32'(inj_count), 32'd3);
    chk("ovr_pending_clr", 32'(inj_pending), 32'd0);
    wait_idle(10);
    chk("ovr_after_data", 32'(data_out), 32'd0);
    chk("ovr_sticky", 32'(inj_overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(inj_overrun), 32'd0);

    // reset in the middle of a pulse with an injection pending
    start_cmd(4'b1111, 4'b1111, 32'd50);
    repeat (10) @(negedge clk);
    inj_trig = 1'b1;
    repeat (4) @(negedge clk);
    inj_trig = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_data", 32'(data_out), 32'b1111);
    chk("mid_pending", 32'(inj_pending), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pending", 32'(inj_pending), 32'd0);
    chk("mid_rst_count", 32'(inj_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_cmd(4'b0011, 4'b0010, 32'd2, 4'b0010, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
